// File: rtl/mult8u_product_accumulator.sv
// mult8u_product_accumulator
//   Sums consecutive unsigned products from the 8x8 multiplier wrapper into
//   dot-product groups of up to LEN beats. A group closes on its LEN-th beat
//   or on a beat flagged in_last. The completed group is held in a
//   single-entry valid/ready output register.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; drops any open group and any
//                pending result
//   in_valid     in_product/in_last valid this cycle
//   in_ready     a beat is accepted this cycle (when in_valid is also high)
//   in_product   unsigned product, PROD_WIDTH bits
//   in_last      this beat closes the group early
//   out_valid    out_sum/out_count/out_overflow hold a completed group
//   out_ready    downstream takes the result this cycle
//   out_sum      group sum (wrapped or clamped, see SATURATE)
//   out_count    number of beats in the group, 1..LEN
//   out_overflow the group sum exceeded 2^ACC_WIDTH-1 at some beat
module mult8u_product_accumulator #(
  parameter int PROD_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int LEN        = 8,
  parameter int SATURATE   = 0,
  parameter int CNT_WIDTH  = $clog2(LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_product,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_overflow
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(LEN - 1);

  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;

  logic                 accept;
  logic                 xfer;
  logic                 close;
  logic                 beat_ovf;
  logic                 new_ovf;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] new_val;
  logic [ACC_WIDTH:0]   full_sum;

  // The output register frees up in the same cycle it is drained, so a new
  // group can close while the previous one is being taken.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  always_comb begin
    // cnt==0 marks a fresh group: acc still holds the previous group's
    // partial value (never cleared on close), so it is masked here.
    base     = (cnt == '0) ? '0 : acc;
    full_sum = {1'b0, base} + (ACC_WIDTH + 1)'(in_product);
    beat_ovf = full_sum[ACC_WIDTH];
    if ((SATURATE != 0) && beat_ovf) begin
      new_val = '1;
    end else begin
      new_val = full_sum[ACC_WIDTH-1:0];
    end
    new_ovf = ((cnt == '0) ? 1'b0 : ovf) | beat_ovf;
    close   = (cnt == LAST_CNT) || in_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b0;
      end
      // A close in the same cycle as a transfer overrides the clear above.
      if (accept) begin
        if (close) begin
          out_sum      <= new_val;
          out_count    <= cnt + CNT_WIDTH'(1);
          out_overflow <= new_ovf;
          out_valid    <= 1'b1;
          cnt          <= '0;
        end else begin
          acc <= new_val;
          ovf <= new_ovf;
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mult8u_product_accumulator.sv
module tb_mult8u_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_product;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_sum;
  logic [3:0]  out_count;
  logic        out_overflow;

  logic        w_in_ready, w_out_valid, w_out_overflow;
  logic [16:0] w_out_sum;
  logic [3:0]  w_out_count;
  logic        s_in_ready, s_out_valid, s_out_overflow;
  logic [16:0] s_out_sum;
  logic [3:0]  s_out_count;

  int checks = 0;
  int errors = 0;
  logic ir_seen;

  always #5 clk = ~clk;

  mult8u_product_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_overflow(out_overflow)
  );

  mult8u_product_accumulator #(.ACC_WIDTH(17), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_product(in_product), .in_last(in_last), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_sum(w_out_sum), .out_count(w_out_count),
    .out_overflow(w_out_overflow)
  );

  mult8u_product_accumulator #(.ACC_WIDTH(17), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_product(in_product), .in_last(in_last), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_sum(s_out_sum), .out_count(s_out_count),
    .out_overflow(s_out_overflow)
  );

  typedef struct {
    logic        iv;
    logic [15:0] prod;
    logic        last;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic [23:0] exp_sum;
    logic [3:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [15:0] prod, input logic last,
                              input logic ordy, input logic exp_ir, input logic exp_ov,
                              input logic [23:0] exp_sum, input logic [3:0] exp_cnt,
                              input logic exp_ovf);
    vec_t v;
    v.iv = iv; v.prod = prod; v.last = last; v.ordy = ordy; v.exp_ir = exp_ir;
    v.exp_ov = exp_ov; v.exp_sum = exp_sum; v.exp_cnt = exp_cnt; v.exp_ovf = exp_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: inputs set mid-low phase, in_ready sampled before the
  // edge, outputs left settled 1 time unit after the edge.
  task automatic cyc(input logic iv, input logic [15:0] p, input logic l,
                     input logic r, input logic do_rst);
    @(negedge clk);
    rst = do_rst; in_valid = iv; in_product = p; in_last = l; out_ready = r;
    #1;
    ir_seen = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [23:0] sum,
                         input logic [3:0] cnt, input logic ovf);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, " out_sum"}, 32'(out_sum), 32'(sum));
    chk({tag, " out_count"}, 32'(out_count), 32'(cnt));
    chk({tag, " out_overflow"}, 32'(out_overflow), 32'(ovf));
  endtask

  initial begin
    static int exp6 [3] = '{36, 100, 164};
    rst = 1'b1; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    cyc(0, 0, 0, 1, 0);
    chk_out("reset", 0, 0, 0, 0);
    chk("reset in_ready", 32'(in_ready), 1);

    // Test 1: eight beats of 255*255
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 65025, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 65025, 0, 1, 1, 1, 520200, 8, 0));
    // Test 2: 3,5,7 closed by in_last; then eight beats of 1
    vecs.push_back(mk(1, 3, 0, 1, 1, 0, 520200, 8, 0));
    vecs.push_back(mk(1, 5, 0, 1, 1, 0, 520200, 8, 0));
    vecs.push_back(mk(1, 7, 1, 1, 1, 1, 15, 3, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 15, 3, 0));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(1, 1, 0, 1, 1, 0, 15, 3, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 1, 8, 8, 0));
    // Test 3: backpressure with stalled beats ignored
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 8, 8, 0));
    vecs.push_back(mk(1, 100, 0, 0, 1, 0, 8, 8, 0));
    vecs.push_back(mk(1, 200, 1, 0, 1, 1, 300, 2, 0));
    vecs.push_back(mk(1, 7, 0, 0, 0, 1, 300, 2, 0));
    vecs.push_back(mk(1, 9, 1, 0, 0, 1, 300, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 300, 2, 0));
    vecs.push_back(mk(1, 4, 0, 1, 1, 0, 300, 2, 0));
    vecs.push_back(mk(1, 6, 1, 1, 1, 1, 10, 2, 0));
    // close in the same cycle as a transfer: register reloads, valid stays 1
    vecs.push_back(mk(1, 5, 1, 1, 1, 1, 5, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 5, 1, 0));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cyc(vecs[i].iv, vecs[i].prod, vecs[i].last, vecs[i].ordy, 0);
      chk({tag, " in_ready"}, 32'(ir_seen), 32'(vecs[i].exp_ir));
      chk_out(tag, vecs[i].exp_ov, vecs[i].exp_sum, vecs[i].exp_cnt, vecs[i].exp_ovf);
    end

    // Test 4: overflow on the 17-bit instances, wrap vs clamp
    cyc(1, 65535, 0, 1, 0);
    cyc(1, 65535, 0, 1, 0);
    cyc(1, 65535, 1, 1, 0);
    chk("wrap out_valid", 32'(w_out_valid), 1);
    chk("wrap out_sum", 32'(w_out_sum), 65533);
    chk("wrap out_count", 32'(w_out_count), 3);
    chk("wrap out_overflow", 32'(w_out_overflow), 1);
    chk("sat out_sum", 32'(s_out_sum), 131071);
    chk("sat out_count", 32'(s_out_count), 3);
    chk("sat out_overflow", 32'(s_out_overflow), 1);
    chk_out("wide", 1, 196605, 3, 0);
    // overflow flag must not carry into the next group
    cyc(1, 1, 0, 1, 0);
    cyc(1, 2, 1, 1, 0);
    chk("wrap next out_sum", 32'(w_out_sum), 3);
    chk("wrap next out_overflow", 32'(w_out_overflow), 0);
    chk("sat next out_sum", 32'(s_out_sum), 3);
    chk("sat next out_overflow", 32'(s_out_overflow), 0);

    // Test 5a: reset mid-group
    for (int i = 0; i < 5; i++) cyc(1, 2, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    chk_out("rst midgroup", 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("rst midgroup in_ready", 32'(ir_seen), 1);
    for (int i = 0; i < 8; i++) cyc(1, 2, 0, 0, 0);
    chk_out("after rst a", 1, 16, 8, 0);
    // Test 5b: reset while a result is pending under backpressure
    cyc(0, 0, 0, 0, 1);
    chk_out("rst pending", 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 2, 0, 1, 0);
    chk_out("after rst b", 1, 16, 8, 0);
    cyc(0, 0, 0, 1, 0);

    // Test 6: continuous stream 1..24, no bubbles
    for (int k = 1; k <= 24; k++) begin
      cyc(1, 16'(k), 0, 1, 0);
      chk($sformatf("stream in_ready k=%0d", k), 32'(ir_seen), 1);
      if (k % 8 == 0) chk_out($sformatf("stream grp%0d", k / 8), 1, 24'(exp6[k/8-1]), 8, 0);
      else chk($sformatf("stream out_valid k=%0d", k), 32'(out_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult8u_product_accumulator.md
Name: mult8u_product_accumulator

Overview:
Downstream consumer of the 8x8 unsigned multiplier wrapper. It takes the registered 16-bit product stream, qualified by a valid bit pipelined alongside the multiplier, and sums consecutive products into dot-product groups. Each completed group sum is presented through a single-entry valid/ready output register. It is the accumulate half of the small MAC datapath used for PPA characterisation of the multiplier variants.

Parameters:
PROD_WIDTH, 16, width of the incoming unsigned product.
ACC_WIDTH, 24, width of the accumulator and of out_sum; must be >= PROD_WIDTH.
LEN, 8, maximum number of products per group; must be >= 1.
SATURATE, 0, 0 = wrap modulo 2^ACC_WIDTH, 1 = clamp at 2^ACC_WIDTH-1.
CNT_WIDTH, $clog2(LEN+1), width of the beat counter and of out_count.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_product/in_last are valid this cycle.
in_ready  output  1  block accepts a beat this cycle.
in_product  input  PROD_WIDTH  unsigned product from the multiplier wrapper.
in_last  input  1  this beat closes the group early.
out_valid  output  1  out_sum/out_count/out_overflow hold a completed group.
out_ready  input  1  downstream takes the result this cycle.
out_sum  output  ACC_WIDTH  group sum.
out_count  output  CNT_WIDTH  beats in the group (1..LEN).
out_overflow  output  1  the group exceeded 2^ACC_WIDTH-1 at any beat (sticky within the group).

Behaviour:
- Beat accepted when in_valid && in_ready. Output transfer when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational from out_ready, with no other dependency.
- Internal state:
  - acc (ACC_WIDTH bits)
  - cnt (CNT_WIDTH bits), number of beats accepted in the open group
  - ovf (sticky flag)
  - output register: out_valid, out_sum, out_count, out_overflow
- On an accepted beat, with base = (cnt==0) ? 0 : acc:
  - Full sum s = base + zero-extended in_product, computed at ACC_WIDTH+1 bits.
  - Beat overflow = s[ACC_WIDTH].
  - New value = SATURATE ? all-ones when overflow, else s[ACC_WIDTH-1:0].
  - New ovf = (cnt==0 ? 0 : ovf) | overflow.
- Group closes on an accepted beat when cnt==LEN-1 or in_last==1, whichever comes first.
  - On close: out_sum <= new value, out_count <= cnt+1, out_overflow <= new ovf, out_valid <= 1, cnt <= 0.
  - Otherwise: acc <= new value, ovf <= new ovf, cnt <= cnt+1.
- Latency: out_valid asserts on the cycle after the closing beat is accepted.
- out_valid clears the cycle after a transfer, unless a new group closes in the same cycle as the transfer; in that case the output register reloads and out_valid stays 1.
- Back-to-back: with out_ready held 1, sustained throughput is one beat per cycle with no bubble between groups.
- Backpressure: while out_valid && !out_ready, in_ready=0. No beats are accepted, acc/cnt/ovf and the outputs hold.
- in_valid=0: nothing changes. A partial group stays open indefinitely.
- LEN=1: every accepted beat is its own group (out_count=1). in_last is ignored in effect.
- rst (synchronous, including mid-group or with out_valid=1): the partial group and any pending output are discarded.
  - Reset values: acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_overflow=0.
  - in_ready reads 1 on the first cycle after rst deasserts.
- Output register fields change only on close or reset.

Test Plan:
1. Defaults; 8 beats of 65025 (255*255), out_ready=1 → one cycle after beat 8: out_valid=1, out_sum=520200, out_count=8, out_overflow=0. in_ready stays 1 throughout.
2. Beats 3, 5, 7 with in_last on the 3rd → out_sum=15, out_count=3. The next 8 beats of 1 then give out_sum=8, out_count=8, with no carry-over from the previous group.
3. out_ready=0 when group 1 closes → out_valid held, in_ready=0, and stalled in_valid beats are not counted. Raising out_ready transfers group 1, and group 2 accumulates from 0 with the correct sums.
4. ACC_WIDTH=17, SATURATE=0: beats 65535, 65535, 65535 with in_last → out_sum=65533 (196605 mod 131072), out_overflow=1. Repeat with SATURATE=1 → out_sum=131071, out_overflow=1.
5. rst pulsed after 5 of 8 beats, and separately while out_valid=1 → all outputs 0 the next cycle. The subsequent 8 beats of 2 give out_sum=16, out_count=8.
6. Continuous stream of 24 beats of value k (k=1..24), out_ready=1, LEN=8 → three results 36, 100, 164, each out_count=8, with no idle cycle on in_ready.
